// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair for the E stage.
// Results are computed from operands captured at accept and written after a fixed busy latency.
module md_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state   | meaning
   // S_IDLE  | no mult/div in flight; accepts new ops, mthi/mtlo write directly
   // S_RUN   | mult/div in flight; counter runs down, result written at count 1

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
   localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;
   logic             busy_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             accept;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;
   logic             wr_d;

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   div_by;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign accept = start & ~cancel & ~busy_q & (op < 3'd6);

   // Signed division works on magnitudes so that most-negative / -1 wraps back to
   // most-negative with a zero remainder instead of depending on tool overflow rules.
   always_comb begin
      prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      a_neg  = (op_q == OP_DIV[1:0]) & a_q[WIDTH-1];
      b_neg  = (op_q == OP_DIV[1:0]) & b_q[WIDTH-1];
      mag_a  = a_neg ? (~a_q + 1'b1) : a_q;
      mag_b  = b_neg ? (~b_q + 1'b1) : b_q;
      div_by = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
      q_mag  = mag_a / div_by;
      r_mag  = mag_a % div_by;
      quo    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
      rem    = a_neg ? (~r_mag + 1'b1) : r_mag;

      hi_d = hi_q;
      lo_d = lo_q;
      wr_d = 1'b0;
      case (op_q)
         OP_MULT[1:0]: begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
            wr_d = 1'b1;
         end
         OP_MULTU[1:0]: begin
            hi_d = prod_u[2*WIDTH-1:WIDTH];
            lo_d = prod_u[WIDTH-1:0];
            wr_d = 1'b1;
         end
         default: begin
            hi_d = rem;
            lo_d = quo;
            wr_d = (b_q != '0);
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op[1:0];
                        cnt_q   <= op[1] ? DIV_CNT : MULT_CNT;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                     end
                     OP_MTHI: hi_q <= a;
                     OP_MTLO: lo_q <= a;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               if (cnt_q == CNT_ONE) begin
                  if (wr_d) begin
                     hi_q <= hi_d;
                     lo_q <= lo_d;
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: two instances (default latencies and 1/3), a per-cycle compare against
// an arithmetic reference model, directed literal checks and a randomized phase.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  start_v = '0;
   logic [1:0]  cancel_v = '0;
   logic [1:0]  busy_w;
   logic [2:0]  op_v[2];
   logic [31:0] a_v[2];
   logic [31:0] b_v[2];
   logic [31:0] hi_w[2];
   logic [31:0] lo_w[2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   md_unit u_big (
      .clk(clk), .reset(rst), .start(start_v[0]), .op(op_v[0]), .cancel(cancel_v[0]),
      .a(a_v[0]), .b(b_v[0]), .busy(busy_w[0]), .hi(hi_w[0]), .lo(lo_w[0])
   );

   md_unit #(.WIDTH(32), .MULT_LAT(1), .DIV_LAT(3)) u_small (
      .clk(clk), .reset(rst), .start(start_v[1]), .op(op_v[1]), .cancel(cancel_v[1]),
      .a(a_v[1]), .b(b_v[1]), .busy(busy_w[1]), .hi(hi_w[1]), .lo(lo_w[1])
   );

   function automatic int lat(input int k, input logic is_div);
      if (k == 0) return is_div ? 10 : 5;
      return is_div ? 3 : 1;
   endfunction

   // reference model: remaining busy cycles plus the pending result
   int          m_rem[2];
   bit          m_pv[2];
   logic [31:0] m_phi[2];
   logic [31:0] m_plo[2];
   logic [31:0] m_hi[2];
   logic [31:0] m_lo[2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_pv[k] = 0;
            m_hi[k] = '0; m_lo[k] = '0; m_phi[k] = '0; m_plo[k] = '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_rem[k] > 0) begin
               m_rem[k]--;
               if (m_rem[k] == 0 && m_pv[k]) begin
                  m_hi[k] = m_phi[k];
                  m_lo[k] = m_plo[k];
               end
            end else if (start_v[k] && !cancel_v[k]) begin
               longint    sa, sb, q, r;
               bit [63:0] p;
               sa = longint'($signed(a_v[k]));
               sb = longint'($signed(b_v[k]));
               case (op_v[k])
                  3'd0: begin
                     p = 64'(sa * sb);
                     m_phi[k] = p[63:32]; m_plo[k] = p[31:0]; m_pv[k] = 1;
                     m_rem[k] = lat(k, 0);
                  end
                  3'd1: begin
                     p = {32'b0, a_v[k]} * {32'b0, b_v[k]};
                     m_phi[k] = p[63:32]; m_plo[k] = p[31:0]; m_pv[k] = 1;
                     m_rem[k] = lat(k, 0);
                  end
                  3'd2: begin
                     m_pv[k] = (b_v[k] != 0);
                     if (m_pv[k]) begin
                        q = sa / sb; r = sa % sb;
                        m_plo[k] = q[31:0]; m_phi[k] = r[31:0];
                     end
                     m_rem[k] = lat(k, 1);
                  end
                  3'd3: begin
                     m_pv[k] = (b_v[k] != 0);
                     if (m_pv[k]) begin
                        m_plo[k] = a_v[k] / b_v[k];
                        m_phi[k] = a_v[k] % b_v[k];
                     end
                     m_rem[k] = lat(k, 1);
                  end
                  3'd4: m_hi[k] = a_v[k];
                  3'd5: m_lo[k] = a_v[k];
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h at %0t", nm, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            check("busy_model", k, {31'b0, busy_w[k]}, {31'b0, (m_rem[k] > 0)});
            check("hi_model", k, hi_w[k], m_hi[k]);
            check("lo_model", k, lo_w[k], m_lo[k]);
         end
      end
   end

   task automatic issue(input int k, input logic [2:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic c);
      @(negedge clk);
      start_v[k] = 1'b1; op_v[k] = o; a_v[k] = aa; b_v[k] = bb; cancel_v[k] = c;
      @(negedge clk);
      start_v[k] = 1'b0; cancel_v[k] = 1'b0;
      a_v[k] = $urandom; b_v[k] = $urandom;
   endtask

   task automatic wait_idle(input int k, output int n);
      n = 0;
      while (busy_w[k] && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      for (int k = 0; k < 2; k++) begin
         op_v[k] = '0; a_v[k] = '0; b_v[k] = '0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_busy", k, {31'b0, busy_w[k]}, 32'h0);
         check("rst_hi", k, hi_w[k], 32'h0);
         check("rst_lo", k, lo_w[k], 32'h0);
      end
      #2 rst = 1'b0;

      issue(0, 3'd1, 32'hFFFF_FFFF, 32'h2, 0);
      wait_idle(0, n);
      check("multu_lat", 0, n, 5);
      check("multu_hi", 0, hi_w[0], 32'h0000_0001);
      check("multu_lo", 0, lo_w[0], 32'hFFFF_FFFE);

      issue(0, 3'd0, 32'hFFFF_FFFD, 32'h4, 0);
      wait_idle(0, n);
      check("mult_lat", 0, n, 5);
      check("mult_hi", 0, hi_w[0], 32'hFFFF_FFFF);
      check("mult_lo", 0, lo_w[0], 32'hFFFF_FFF4);

      issue(0, 3'd2, 32'hFFFF_FFF9, 32'h2, 0);
      wait_idle(0, n);
      check("div_lat", 0, n, 10);
      check("div_lo", 0, lo_w[0], 32'hFFFF_FFFD);
      check("div_hi", 0, hi_w[0], 32'hFFFF_FFFF);

      issue(0, 3'd3, 32'h5, 32'h0, 0);
      wait_idle(0, n);
      check("divu0_lat", 0, n, 10);
      check("divu0_lo", 0, lo_w[0], 32'hFFFF_FFFD);
      check("divu0_hi", 0, hi_w[0], 32'hFFFF_FFFF);

      issue(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      wait_idle(0, n);
      check("divovf_lo", 0, lo_w[0], 32'h8000_0000);
      check("divovf_hi", 0, hi_w[0], 32'h0000_0000);

      issue(0, 3'd0, 32'h7, 32'h9, 1);
      check("cancel_busy", 0, {31'b0, busy_w[0]}, 32'h0);
      check("cancel_lo", 0, lo_w[0], 32'h8000_0000);

      issue(0, 3'd5, 32'h1234_5678, 32'h0, 0);
      check("mtlo_lo", 0, lo_w[0], 32'h1234_5678);
      check("mtlo_busy", 0, {31'b0, busy_w[0]}, 32'h0);
      check("mtlo_hi", 0, hi_w[0], 32'h0000_0000);

      issue(0, 3'd4, 32'hABCD_0001, 32'h0, 0);
      check("mthi_hi", 0, hi_w[0], 32'hABCD_0001);
      check("mthi_lo", 0, lo_w[0], 32'h1234_5678);

      issue(0, 3'd6, 32'h5, 32'h5, 0);
      check("rsvd_busy", 0, {31'b0, busy_w[0]}, 32'h0);

      // start arriving during the 2nd busy cycle of a divide must be dropped
      issue(0, 3'd2, 32'd100, 32'd7, 0);
      issue(0, 3'd0, 32'd3, 32'd3, 0);
      wait_idle(0, n);
      check("overlap_lat", 0, n + 2, 10);
      check("overlap_lo", 0, lo_w[0], 32'd14);
      check("overlap_hi", 0, hi_w[0], 32'd2);

      issue(1, 3'd0, 32'd6, 32'd7, 0);
      wait_idle(1, n);
      check("small_mult_lat", 1, n, 1);
      check("small_mult_lo", 1, lo_w[1], 32'd42);
      issue(1, 3'd2, 32'd100, 32'd7, 0);
      issue(1, 3'd0, 32'd3, 32'd3, 0);
      wait_idle(1, n);
      check("small_div_lat", 1, n + 2, 3);
      check("small_div_lo", 1, lo_w[1], 32'd14);
      check("small_div_hi", 1, hi_w[1], 32'd2);

      // asynchronous reset three cycles into a divide
      issue(0, 3'd2, 32'd1000, 32'd3, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 0, {31'b0, busy_w[0]}, 32'h0);
      check("arst_hi", 0, hi_w[0], 32'h0);
      check("arst_lo", 0, lo_w[0], 32'h0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (15) @(negedge clk);
      check("arst_late_hi", 0, hi_w[0], 32'h0);
      check("arst_late_lo", 0, lo_w[0], 32'h0);

      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            start_v[k]  = ($urandom_range(0, 1) == 1);
            cancel_v[k] = ($urandom_range(0, 7) == 0);
            op_v[k]     = 3'($urandom_range(0, 7));
            a_v[k]      = pick();
            b_v[k]      = pick();
         end
      end
      @(negedge clk);
      start_v = '0;
      repeat (12) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
